brq_ifu_fetch_req: RTL and testbench

Instruction-bus request engine: the producer side of the IFU fetch FIFO (brq_ifu_fifo).
- Issues word-aligned fetch requests on the req/gnt/rvalid instruction bus.
- Tracks up to NUM_REQS in-flight requests and discards responses made stale by a branch.
- Pushes surviving responses into the FIFO input port and drives the FIFO clear/target address on branches.
- Sits between the IF stage control (req/branch) and the instruction memory bus.

---
 rtl/brq_ifu_fetch_req.sv | 177 +++++++++++++++++
 tb/tb_brq_ifu_fetch_req.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/brq_ifu_fetch_req.sv
// IFU fetch request engine: issues word-aligned instruction bus requests, tracks
// in-flight responses and feeds survivors into the fetch FIFO. Optional: BRQ_IFU_ERR_STOP_EN.
module brq_ifu_fetch_req #(
  parameter int NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_clear_o,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i,
  output logic                busy_o
);

  typedef enum logic {IDLE, WAIT_GNT} state_e;

  state_e              state_q;
  logic [31:0]         fetch_addr_q;
  logic [31:0]         req_addr_q;
  logic                discard_pending_q;
  logic [2:0]          cnt_q;
  logic [2:0]          cnt_d;
  logic [NUM_REQS-1:0] disc_q;
  logic [NUM_REQS-1:0] disc_d;

  logic [31:0]         target;
  logic [NUM_REQS-1:0] busy_eff;
  logic [2:0]          busy_cnt;
  logic                slot_ok;
  logic                err_stop;
  logic                idle_req;
  logic                push;
  logic                pop;
  logic                push_disc;
  logic [2:0]          push_idx;

  assign target   = {addr_i[31:2], 2'b00};
  // A branch clears the FIFO this cycle, so its occupancy no longer limits us
  assign busy_eff = branch_i ? '0 : fifo_busy_i;

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      busy_cnt = busy_cnt + {2'b00, busy_eff[i]};
    end
  end

  assign slot_ok = (cnt_q < 3'(NUM_REQS)) &
                   (({1'b0, cnt_q} + {1'b0, busy_cnt}) < 4'(NUM_REQS));

  assign idle_req     = req_i & slot_ok & ~(err_stop & ~branch_i);
  assign instr_req_o  = (state_q == WAIT_GNT) | idle_req;
  assign instr_addr_o = (state_q == WAIT_GNT) ? req_addr_q :
                        (branch_i ? target : fetch_addr_q);

  assign push = instr_req_o & instr_gnt_i;
  assign pop  = instr_rvalid_i & (cnt_q != 3'd0);

  // An IDLE request issued with a branch already targets the new address and is kept;
  // only a held WAIT_GNT request overtaken by a branch is stale.
  assign push_disc = (state_q == WAIT_GNT) & (discard_pending_q | branch_i);

  assign fifo_valid_o = pop & ~disc_q[0] & ~branch_i;
  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = addr_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;
  assign busy_o       = (state_q == WAIT_GNT) | (cnt_q != 3'd0);

  // In-order discard queue: head at index 0, pop shifts down, push lands after survivors
  assign push_idx = cnt_q - {2'b00, pop};

  always_comb begin
    disc_d = disc_q;
    if (pop) begin
      for (int i = 0; i < NUM_REQS - 1; i++) begin
        disc_d[i] = disc_q[i+1];
      end
      disc_d[NUM_REQS-1] = 1'b0;
    end
    if (branch_i) begin
      disc_d = '1;
    end
    if (push) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (push_idx == 3'(i)) disc_d[i] = push_disc;
      end
    end
    cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      disc_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      disc_q <= disc_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q           <= IDLE;
      fetch_addr_q      <= '0;
      req_addr_q        <= '0;
      discard_pending_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (idle_req) begin
            if (instr_gnt_i) begin
              fetch_addr_q <= instr_addr_o + 32'd4;
            end else begin
              state_q           <= WAIT_GNT;
              req_addr_q        <= instr_addr_o;
              fetch_addr_q      <= instr_addr_o;
              discard_pending_q <= 1'b0;
            end
          end else if (branch_i) begin
            fetch_addr_q <= target;
          end
        end
        WAIT_GNT: begin
          if (instr_gnt_i) begin
            state_q           <= IDLE;
            discard_pending_q <= 1'b0;
            if (branch_i)                fetch_addr_q <= target;
            else if (!discard_pending_q) fetch_addr_q <= req_addr_q + 32'd4;
          end else if (branch_i) begin
            discard_pending_q <= 1'b1;
            fetch_addr_q      <= target;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef BRQ_IFU_ERR_STOP_EN
  logic err_stop_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_stop_q <= 1'b0;
    end else if (branch_i) begin
      err_stop_q <= 1'b0;
    end else if (fifo_valid_o & instr_err_i) begin
      err_stop_q <= 1'b1;
    end
  end

  assign err_stop = err_stop_q;
`else
  assign err_stop = 1'b0;
`endif

`ifndef SYNTHESIS
  rvalid_needs_outstanding: assert property (
    @(posedge clk_i) disable iff (!rst_ni) instr_rvalid_i |-> (cnt_q != 3'd0));
  wait_gnt_addr_stable: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
      (state_q == WAIT_GNT) && !instr_gnt_i |=> (instr_req_o && $stable(instr_addr_o)));
`endif

endmodule

// File: tb/tb_brq_ifu_fetch_req.sv
// Scoreboard bench for brq_ifu_fetch_req: directed fetch/branch/stall scenarios with
// a latency-programmable bus model; expected FIFO pushes are queued and checked by a monitor.
module tb_brq_ifu_fetch_req;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, branch, gnt, rvalid, rerr;
  logic [31:0] addr, rdata;
  logic [1:0]  fbusy;
  logic        fifo_clear, fifo_valid, fifo_err, instr_req, busy;
  logic [31:0] fifo_addr, fifo_rdata, instr_addr;

  int nchk = 0;
  int nerr = 0;
  int lat  = 1;
  int cyc  = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic [32:0] exp_q[$];
  logic [31:0] pa[$];
  int          pd[$];

  brq_ifu_fetch_req #(.NUM_REQS(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .branch_i(branch), .addr_i(addr),
    .fifo_busy_i(fbusy), .fifo_clear_o(fifo_clear), .fifo_valid_o(fifo_valid),
    .fifo_addr_o(fifo_addr), .fifo_rdata_o(fifo_rdata), .fifo_err_o(fifo_err),
    .instr_req_o(instr_req), .instr_gnt_i(gnt), .instr_addr_o(instr_addr),
    .instr_rvalid_i(rvalid), .instr_rdata_i(rdata), .instr_err_i(rerr), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    step();
    req = 0; branch = 0; fbusy = 2'b00;
    repeat (5) step();
    @(negedge clk);
    chk(name, busy, 1'b0);
  endtask

  // Bus model: in-order responses, each due lat cycles after its grant
  initial begin
    rvalid = 0; rdata = '0; rerr = 0;
    forever begin
      @(negedge clk);
      if (rst_n && instr_req && gnt) begin
        pa.push_back(instr_addr);
        pd.push_back(cyc + lat);
      end
      @(posedge clk);
      cyc++;
      #1;
      if (pa.size() != 0 && pd[0] <= cyc) begin
        rvalid = 1;
        rdata  = 32'hD000_0000 | pa[0];
        rerr   = (pa[0] == err_addr);
        void'(pa.pop_front());
        void'(pd.pop_front());
      end else begin
        rvalid = 0;
      end
    end
  end

  // Monitor: every FIFO push must match the oldest expected response
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && fifo_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_push", {fifo_err, fifo_rdata}, 33'h1_FFFF_FFFF);
        end else begin
          chk("push_data", {fifo_err, fifo_rdata}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic found;
    rst_n = 0; req = 0; branch = 0; addr = '0; gnt = 0; fbusy = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", instr_req, 1'b0);
    chk("rst_fifo_valid", fifo_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", instr_addr, 32'h0);
    rst_n = 1;

    // Sequential fetch from reset, one-cycle response latency
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'(4 * i);
      step(); req = 1; gnt = 1;
      @(negedge clk);
      chk("t1_req", instr_req, 1'b1);
      chk("t1_addr", instr_addr, a);
      exp_q.push_back({1'b0, 32'hD000_0000 | a});
    end
    drain("t1_idle");

    // Branch in IDLE to a halfword address
    step(); req = 1; gnt = 1; branch = 1; addr = 32'h0000_1002;
    @(negedge clk);
    chk("t2_addr", instr_addr, 32'h0000_1000);
    chk("t2_clear", fifo_clear, 1'b1);
    chk("t2_fifo_addr", fifo_addr, 32'h0000_1002);
    exp_q.push_back({1'b0, 32'hD000_1000});
    step(); branch = 0;
    @(negedge clk);
    chk("t2_next", instr_addr, 32'h0000_1004);
    exp_q.push_back({1'b0, 32'hD000_1004});
    drain("t2_idle");

    // Two outstanding (0x20, 0x24) overtaken by a branch to 0x80
    step(); branch = 1; addr = 32'h20; req = 0; lat = 3;
    step(); branch = 0; req = 1;
    @(negedge clk);
    chk("t3_addr0", instr_addr, 32'h20);
    step();
    @(negedge clk);
    chk("t3_addr1", instr_addr, 32'h24);
    step(); branch = 1; addr = 32'h80;
    @(negedge clk);
    chk("t3_full", instr_req, 1'b0);
    step(); branch = 0;
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      if (instr_req) begin
        chk("t3_target", instr_addr, 32'h80);
        exp_q.push_back({1'b0, 32'hD000_0080});
        found = 1;
      end else begin
        step();
      end
    end
    if (!found) chk("t3_timeout", 1'b0, 1'b1);
    drain("t3_idle");
    lat = 1;

    // Stalled grant at 0x40 with a branch to 0x100 while waiting
    step(); branch = 1; addr = 32'h40; req = 0;
    step(); branch = 0; req = 1; gnt = 0;
    @(negedge clk);
    chk("t4_req", instr_req, 1'b1);
    chk("t4_addr0", instr_addr, 32'h40);
    step(); branch = 1; addr = 32'h100;
    @(negedge clk);
    chk("t4_addr1", instr_addr, 32'h40);
    chk("t4_busy", busy, 1'b1);
    step(); branch = 0; req = 0;
    @(negedge clk);
    chk("t4_hold_req", instr_req, 1'b1);
    chk("t4_addr2", instr_addr, 32'h40);
    step(); req = 1; gnt = 1;
    @(negedge clk);
    chk("t4_addr_gnt", instr_addr, 32'h40);
    step();
    @(negedge clk);
    chk("t4_target", instr_addr, 32'h100);
    exp_q.push_back({1'b0, 32'hD000_0100});
    drain("t4_idle");

    // FIFO occupancy limits issue
    step(); fbusy = 2'b11; req = 1; gnt = 1; lat = 3;
    @(negedge clk);
    chk("t5_block0", instr_req, 1'b0);
    step();
    @(negedge clk);
    chk("t5_block1", instr_req, 1'b0);
    step(); fbusy = 2'b01;
    @(negedge clk);
    chk("t5_one_req", instr_req, 1'b1);
    chk("t5_one_addr", instr_addr, 32'h104);
    exp_q.push_back({1'b0, 32'hD000_0104});
    step();
    @(negedge clk);
    chk("t5_only_one", instr_req, 1'b0);
    drain("t5_idle");
    step(); fbusy = 2'b11; branch = 1; addr = 32'h200; req = 1;
    @(negedge clk);
    chk("t5_br_req", instr_req, 1'b1);
    chk("t5_br_addr", instr_addr, 32'h200);
    exp_q.push_back({1'b0, 32'hD000_0200});
    drain("t5_br_idle");
    lat = 1;

    // Error response handling
    step(); branch = 1; addr = 32'h300; req = 1; gnt = 1; err_addr = 32'h300;
    @(negedge clk);
    chk("t6_addr0", instr_addr, 32'h300);
    exp_q.push_back({1'b1, 32'hD000_0300});
    step(); branch = 0;
    @(negedge clk);
    chk("t6_addr1", instr_addr, 32'h304);
    exp_q.push_back({1'b0, 32'hD000_0304});
    for (int j = 0; j < 2; j++) begin
      step();
      @(negedge clk);
`ifdef BRQ_IFU_ERR_STOP_EN
      chk("t6_stopped", instr_req, 1'b0);
`else
      begin
        logic [31:0] a;
        a = 32'h308 + 32'(4 * j);
        chk("t6_cont_req", instr_req, 1'b1);
        chk("t6_cont_addr", instr_addr, a);
        exp_q.push_back({1'b0, 32'hD000_0000 | a});
      end
`endif
    end
    step(); req = 0;
    step(); branch = 1; addr = 32'h400; req = 1;
    @(negedge clk);
    chk("t6_br_req", instr_req, 1'b1);
    chk("t6_br_addr", instr_addr, 32'h400);
    exp_q.push_back({1'b0, 32'hD000_0400});
    drain("t6_idle");

    chk("sb_empty", 33'(exp_q.size()), 33'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
